// File: rtl/wvb_readout_arb.sv
// -----------------------------------------------------------------------------
// wvb_readout_arb
//
// Round-robin readout arbiter for P_N_CHAN waveform buffer channels. A channel
// with a pending header (and arbitration enabled) is granted. Its header is
// latched, and the event is streamed out of that channel's waveform buffer.
// The samples are merged into a single ready/valid stream with the header
// attached. On completion, the channel's header is popped and its buffer is
// told that the event read is done.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   chan_en       per-channel arbitration enable
//   hdr_empty     per-channel header FIFO empty (first-word fall-through)
//   hdr_data      per-channel header, channel i at [i*P_HDR_WIDTH +: P_HDR_WIDTH]
//   wvb_data      per-channel sample data, valid one cycle after wvb_rdreq
//   hdr_rdreq     header pop pulse (granted channel only)
//   wvb_rdreq     sample read request (granted channel only)
//   wvb_rddone    event-read-complete pulse (granted channel only)
//   dout          output sample
//   dout_hdr      header of the event being streamed
//   dout_chan     channel of the event being streamed
//   dout_valid    output word valid; dout_ready accepts it
//   dout_sop      first sample of the event
//   dout_eop      last sample of the event
//   busy          event in progress (LATCH and STREAM)
//   evt_cnt       completed-event counter
//
// Header layout: stop address in [P_ADR_WIDTH-1:0], start address in
// [2*P_ADR_WIDTH-1:P_ADR_WIDTH]. The sample count is (stop-start) mod
// 2^P_ADR_WIDTH, plus 1.
//
// Optional feature, macro WVB_ARB_EVT_CNT_EN: when the macro is defined,
// evt_cnt counts completed events. It is cleared while idle with every
// chan_en bit low. When the macro is undefined, evt_cnt is tied to zero.
// -----------------------------------------------------------------------------
module wvb_readout_arb #(
   parameter int P_N_CHAN     = 4,
   parameter int P_CHAN_WIDTH = 2,
   parameter int P_DATA_WIDTH = 22,
   parameter int P_ADR_WIDTH  = 12,
   parameter int P_HDR_WIDTH  = 80
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [P_N_CHAN-1:0]              chan_en,
   input  logic [P_N_CHAN-1:0]              hdr_empty,
   input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]  hdr_data,
   input  logic [P_N_CHAN*P_DATA_WIDTH-1:0] wvb_data,
   output logic [P_N_CHAN-1:0]              hdr_rdreq,
   output logic [P_N_CHAN-1:0]              wvb_rdreq,
   output logic [P_N_CHAN-1:0]              wvb_rddone,
   output logic [P_DATA_WIDTH-1:0]          dout,
   output logic [P_HDR_WIDTH-1:0]           dout_hdr,
   output logic [P_CHAN_WIDTH-1:0]          dout_chan,
   output logic                             dout_valid,
   output logic                             dout_sop,
   output logic                             dout_eop,
   input  logic                             dout_ready,
   output logic                             busy,
   output logic [31:0]                      evt_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_LATCH, S_STREAM, S_DONE} state_t;

   state_t                   state, state_nxt;
   logic [P_CHAN_WIDTH-1:0]  ptr;
   logic [P_N_CHAN-1:0]      req;
   logic                     gnt_vld;
   logic [P_CHAN_WIDTH-1:0]  gnt_idx;
   logic [P_N_CHAN-1:0]      chan_oh;
   logic [P_ADR_WIDTH:0]     cnt_n, issued, delivered;
   logic                     vld_p0;     // read issued last cycle, sample on wvb_data now
   logic [P_DATA_WIDTH-1:0]  rd_sample_p0;
   logic [P_DATA_WIDTH-1:0]  sk_data1;   // second skid entry; the head entry is dout
   logic [1:0]               sk_cnt;
   logic                     pop, issue;
   logic [2:0]               occ;

   // Sample count from the start/stop address pair, with address wrap.
   function automatic logic [P_ADR_WIDTH:0] evt_len(input logic [2*P_ADR_WIDTH-1:0] adr);
      logic [P_ADR_WIDTH-1:0] span;
      span = adr[P_ADR_WIDTH-1:0] - adr[2*P_ADR_WIDTH-1:P_ADR_WIDTH];
      return {1'b0, span} + {{P_ADR_WIDTH{1'b0}}, 1'b1};
   endfunction

   // Round robin: scan downward from the pointer itself (lowest priority) to the
   // channel just after it, so the last hit is the first requester after ptr.
   always_comb begin
      int idx;
      req     = ~hdr_empty & chan_en;
      gnt_vld = 1'b0;
      gnt_idx = ptr;
      idx     = 0;
      for (int k = P_N_CHAN; k >= 1; k--) begin
         idx = (int'(ptr) + k) % P_N_CHAN;
         if (req[idx[P_CHAN_WIDTH-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx[P_CHAN_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      chan_oh            = '0;
      chan_oh[dout_chan] = 1'b1;
      rd_sample_p0       = wvb_data[dout_chan*P_DATA_WIDTH +: P_DATA_WIDTH];
      dout_valid         = (state == S_STREAM) && (sk_cnt != 2'd0);
      pop                = dout_valid && dout_ready;
      // Reads in flight plus skid fill after this cycle's pop; keeping the sum
      // at most 2 means the skid can never overflow, yet it sustains 1 word/cycle.
      occ                = 3'(vld_p0) + 3'(sk_cnt) - 3'(pop);
      issue              = (state == S_STREAM) && (issued < cnt_n) && (occ < 3'd2);
      wvb_rdreq          = issue ? chan_oh : '0;
      wvb_rddone         = (state == S_DONE) ? chan_oh : '0;
      hdr_rdreq          = (state == S_DONE) ? chan_oh : '0;
      dout_sop           = dout_valid && (delivered == '0);
      dout_eop           = dout_valid && (delivered == cnt_n - 1'b1);
      busy               = (state == S_LATCH) || (state == S_STREAM);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (gnt_vld) state_nxt = S_LATCH;
         S_LATCH:  state_nxt = S_STREAM;
         S_STREAM: if (pop && dout_eop) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Stage p0: grant, header latch, read issue and delivery accounting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= P_CHAN_WIDTH'(P_N_CHAN - 1);
         dout_chan <= '0;
         dout_hdr  <= '0;
         cnt_n     <= '0;
         issued    <= '0;
         delivered <= '0;
         vld_p0    <= 1'b0;
      end else begin
         state  <= state_nxt;
         vld_p0 <= issue;
         case (state)
            S_IDLE: if (gnt_vld) begin
               dout_chan <= gnt_idx;
               dout_hdr  <= hdr_data[gnt_idx*P_HDR_WIDTH +: P_HDR_WIDTH];
               ptr       <= gnt_idx;
            end
            S_LATCH: begin
               cnt_n     <= evt_len(dout_hdr[2*P_ADR_WIDTH-1:0]);
               issued    <= '0;
               delivered <= '0;
            end
            S_STREAM: begin
               if (issue) issued    <= issued + 1'b1;
               if (pop)   delivered <= delivered + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Stage p1: returned samples enter the 2-entry skid; the head is dout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout     <= '0;
         sk_data1 <= '0;
         sk_cnt   <= 2'd0;
      end else begin
         case ({vld_p0, pop})
            2'b10: begin
               if (sk_cnt == 2'd0) dout <= rd_sample_p0;
               else                sk_data1 <= rd_sample_p0;
               sk_cnt <= sk_cnt + 2'd1;
            end
            2'b01: begin
               dout   <= sk_data1;
               sk_cnt <= sk_cnt - 2'd1;
            end
            2'b11: begin
               if (sk_cnt == 2'd1) dout <= rd_sample_p0;
               else begin
                  dout     <= sk_data1;
                  sk_data1 <= rd_sample_p0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef WVB_ARB_EVT_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      evt_cnt <= '0;
      else if (state == S_DONE)                     evt_cnt <= evt_cnt + 32'd1;
      else if (state == S_IDLE && chan_en == '0)    evt_cnt <= '0;
   end
`else
   assign evt_cnt = '0;
`endif

endmodule

// File: tb/tb_wvb_readout_arb.sv
module tb_wvb_readout_arb;
   localparam int NC = 4;
   localparam int CW = 2;
   localparam int DW = 22;
   localparam int AW = 12;
   localparam int HW = 80;
`ifdef WVB_ARB_EVT_CNT_EN
   localparam bit EVT_EN = 1'b1;
`else
   localparam bit EVT_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NC-1:0]     chan_en, hdr_empty;
   logic [NC*HW-1:0]  hdr_data;
   logic [NC*DW-1:0]  wvb_data;
   logic [NC-1:0]     hdr_rdreq, wvb_rdreq, wvb_rddone;
   logic [DW-1:0]     dout;
   logic [HW-1:0]     dout_hdr;
   logic [CW-1:0]     dout_chan;
   logic              dout_valid, dout_sop, dout_eop, dout_ready, busy;
   logic [31:0]       evt_cnt;

   int ncomp = 0;
   int nfail = 0;

   // Waveform buffer model: each read returns {channel, per-channel read index}.
   logic              rc_clr;
   logic [15:0]       rcount [NC];

   always #5 clk = ~clk;

   wvb_readout_arb dut (
      .clk(clk), .rst(rst), .chan_en(chan_en), .hdr_empty(hdr_empty),
      .hdr_data(hdr_data), .wvb_data(wvb_data), .hdr_rdreq(hdr_rdreq),
      .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone), .dout(dout),
      .dout_hdr(dout_hdr), .dout_chan(dout_chan), .dout_valid(dout_valid),
      .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_ready(dout_ready),
      .busy(busy), .evt_cnt(evt_cnt)
   );

   always @(posedge clk) begin
      for (int i = 0; i < NC; i++) begin
         if (rc_clr) rcount[i] <= '0;
         else if (wvb_rdreq[i]) begin
            wvb_data[i*DW +: DW] <= DW'((i << 16) | int'(rcount[i]));
            rcount[i] <= rcount[i] + 16'd1;
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, 128'({wvb_rdreq, wvb_rddone, hdr_rdreq, dout, dout_hdr, dout_chan,
                     dout_valid, dout_sop, dout_eop, busy}), 128'(0));
      chk({tag, "_evt"}, 128'(evt_cnt), 128'(0));
   endtask

   task automatic set_hdr(input int ch, input logic [AW-1:0] start, input logic [AW-1:0] stop);
      hdr_data[ch*HW +: HW] = {32'(32'hDEAD_0000 + ch), 24'h0, start, stop};
   endtask

   task automatic clr_buf();
      rc_clr = 1'b1;
      @(negedge clk);
      rc_clr = 1'b0;
   endtask

   // Waits for a grant of channel ch and follows its event word by word.
   // stop_after > 0 returns right after that many words, before the transfer edge.
   task automatic collect(input int ch, input int n, input bit tog,
                          input bit clr_empty, input int stop_after);
      int k, iss, cyc, want;
      logic [NC-1:0] oh;
      logic [HW-1:0] exp_hdr;
      logic [DW-1:0] pd;
      logic ps, pe, pstall;
      oh   = NC'(1 << ch);
      want = (stop_after > 0) ? stop_after : n;
      cyc  = 0;
      while (!busy && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("grant_busy", 128'(busy), 128'(1));
      exp_hdr = hdr_data[ch*HW +: HW];
      if (clr_empty) begin
         hdr_empty[ch] = 1'b1;
         hdr_data[ch*HW +: HW] = '1;
      end
      chk("chan", 128'(dout_chan), 128'(ch));
      chk("hdr", 128'(dout_hdr), 128'(exp_hdr));
      k = 0; iss = 0; pstall = 1'b0; pd = '0; ps = 1'b0; pe = 1'b0;
      for (cyc = 0; cyc < 400; cyc++) begin
         if (tog) dout_ready = ((cyc % 2) == 0);
         else     dout_ready = 1'b1;
         #1;
         chk("rdreq_sel", 128'(wvb_rdreq & ~oh), 128'(0));
         if (wvb_rdreq != '0) iss++;
         if (pstall)
            chk("stall_stable", 128'({dout_valid, dout_sop, dout_eop, dout}),
                128'({1'b1, ps, pe, pd}));
         if (!tog && k > 0) chk("gapless", 128'(dout_valid), 128'(1));
         if (dout_valid && dout_ready) begin
            chk("data", 128'(dout), 128'(DW'((ch << 16) | k)));
            chk("sop", 128'(dout_sop), 128'(k == 0));
            chk("eop", 128'(dout_eop), 128'(k == n - 1));
            k++;
         end
         chk("occupancy", 128'((iss - k) <= 2), 128'(1));
         if (k == want) break;
         pstall = dout_valid && !dout_ready;
         pd = dout; ps = dout_sop; pe = dout_eop;
         @(negedge clk);
      end
      chk("word_count", 128'(k), 128'(want));
      if (stop_after == 0) begin
         @(negedge clk);
         chk("done_pulse", 128'({wvb_rddone, hdr_rdreq, busy}), 128'({oh, oh, 1'b0}));
         chk("reads_issued", 128'(iss), 128'(n));
         @(negedge clk);
         chk("done_end", 128'({wvb_rddone, hdr_rdreq, busy}), 128'(0));
      end
   endtask

   initial begin
      int p, cyc;
      int order [11];
      order = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3};

      rst = 1'b1; rc_clr = 1'b1;
      chan_en = '1; hdr_empty = '1; hdr_data = '0; dout_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("reset_state");
      rst = 1'b0; rc_clr = 1'b0;
      @(negedge clk);
      chk("idle_quiet", 128'({busy, wvb_rdreq, dout_valid}), 128'(0));

      // Single event on ch1, 4 samples; hdr_empty rises mid-event
      clr_buf();
      set_hdr(1, 12'h010, 12'h013); hdr_empty[1] = 1'b0;
      collect(1, 4, 1'b0, 1'b1, 0);

      // Address wrap: 0xFFE..0x001 is 4 samples
      clr_buf();
      set_hdr(2, 12'hFFE, 12'h001); hdr_empty[2] = 1'b0;
      collect(2, 4, 1'b0, 1'b1, 0);

      // start == stop: one sample with sop and eop together
      clr_buf();
      set_hdr(3, 12'h005, 12'h005); hdr_empty[3] = 1'b0;
      collect(3, 1, 1'b0, 1'b1, 0);

      // 16-sample event under alternating backpressure
      clr_buf();
      set_hdr(0, 12'h100, 12'h10F); hdr_empty[0] = 1'b0;
      collect(0, 16, 1'b1, 1'b1, 0);

      // Async reset in the middle of an 8-sample event, then a full replay
      clr_buf();
      set_hdr(2, 12'h020, 12'h027); hdr_empty[2] = 1'b0;
      collect(2, 8, 1'b0, 1'b0, 3);
      #2 rst = 1'b1; rc_clr = 1'b1;
      #1 chk_zero("async_reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; rc_clr = 1'b0;
      collect(2, 8, 1'b0, 1'b1, 0);

      // Fairness with every channel requesting; ch1 disabled after 8 events
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NC; i++) set_hdr(i, 12'(i * 16), 12'(i * 16));
      hdr_empty = '0; dout_ready = 1'b1;
      p = 0; cyc = 0;
      while (p < 11 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (hdr_rdreq != '0) begin
            chk("rr_order", 128'({hdr_rdreq, wvb_rddone}),
                128'({NC'(1 << order[p]), NC'(1 << order[p])}));
            p++;
            if (p == 8)  chan_en = 4'b1101;
            if (p == 11) hdr_empty = '1;
            if (p == 5) begin
               @(negedge clk);
               cyc++;
               chk("evt_cnt_5", 128'(evt_cnt), EVT_EN ? 128'(5) : 128'(0));
            end
         end
      end
      chk("rr_count", 128'(p), 128'(11));
      repeat (4) @(negedge clk);
      chk("idle_after_rr", 128'({busy, dout_valid}), 128'(0));
      chk("evt_cnt_11", 128'(evt_cnt), EVT_EN ? 128'(11) : 128'(0));
      chan_en = '0;
      @(negedge clk);
      @(negedge clk);
      chk("evt_cnt_clear", 128'(evt_cnt), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end
endmodule

// File: doc/wvb_readout_arb.md
Name: wvb_readout_arb

Overview:
- Round-robin readout arbiter serving P_N_CHAN waveform buffer channels.
- Selects one channel that has a pending header and drives that channel's header/waveform read handshake (hdr_rdreq, wvb_rdreq, wvb_rddone).
- Merges the selected event into a single ready/valid sample stream, with the header attached, for the downstream packetizer.
- Sits between the per-channel waveform buffers and the shared readout path.

Parameters:
- P_N_CHAN, 4, number of waveform buffer channels (2..16).
- P_CHAN_WIDTH, 2, width of the channel index; must be ≥ clog2(P_N_CHAN).
- P_DATA_WIDTH, 22, waveform sample width.
- P_ADR_WIDTH, 12, waveform storage address width.
- P_HDR_WIDTH, 80, header word width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- chan_en  in  P_N_CHAN  per-channel arbitration enable
- hdr_empty  in  P_N_CHAN  per-channel header FIFO empty (FWFT)
- hdr_data  in  P_N_CHAN*P_HDR_WIDTH  per-channel header; channel i at bits [i*P_HDR_WIDTH +: P_HDR_WIDTH]
- wvb_data  in  P_N_CHAN*P_DATA_WIDTH  per-channel sample data; valid 1 cycle after wvb_rdreq
- hdr_rdreq  out  P_N_CHAN  header pop, one-cycle pulse
- wvb_rdreq  out  P_N_CHAN  sample read request
- wvb_rddone  out  P_N_CHAN  event-read-complete pulse
- dout  out  P_DATA_WIDTH  sample
- dout_hdr  out  P_HDR_WIDTH  latched header of the current event
- dout_chan  out  P_CHAN_WIDTH  channel of the current event
- dout_valid  out  1  output word valid
- dout_sop  out  1  first sample of the event
- dout_eop  out  1  last sample of the event
- dout_ready  in  1  downstream accept
- busy  out  1  event in progress
- evt_cnt  out  32  completed-event counter (optional feature)

Behaviour:
- Reset (async): all outputs 0, state IDLE, round-robin pointer = P_N_CHAN-1, so channel 0 has first priority. Reset mid-event abandons the event with no rddone/hdr_rdreq pulses.
- Header layout (fixed):
  - stop address = hdr[P_ADR_WIDTH-1:0]
  - start address = hdr[2*P_ADR_WIDTH-1:P_ADR_WIDTH]
  - sample count N = ((stop − start) mod 2^P_ADR_WIDTH) + 1, so the address wraps and N ranges 1..2^P_ADR_WIDTH.
  - Count register is P_ADR_WIDTH+1 bits.
- State machine IDLE → LATCH → STREAM → DONE → IDLE.
- IDLE:
  - Requesting set = ~hdr_empty & chan_en.
  - Grant = first requester after the pointer, searching upward with wrap.
  - If no requester, stay in IDLE.
  - On grant: latch the channel into dout_chan, latch the header into dout_hdr, update the pointer to the granted channel, assert busy, go to LATCH.
- LATCH: one cycle; compute N, reset the issued and delivered counters; go to STREAM.
- STREAM:
  - Assert wvb_rdreq[chan] only while issued < N and (outstanding reads + skid entries) < 2.
  - The skid buffer is 2 entries deep.
  - Returned samples enter the skid buffer; its head drives dout/dout_valid.
  - A word transfers when dout_valid && dout_ready.
  - dout_sop = 1 on the word with delivered == 0.
  - dout_eop = 1 on the word with delivered == N−1 (N = 1 gives sop and eop on the same word).
  - dout, dout_valid, dout_sop and dout_eop stay stable while dout_valid && !dout_ready.
  - At most one wvb_rdreq per cycle. Full throughput: 1 word/cycle with dout_ready held high.
- DONE:
  - Entered on the cycle after the eop transfer.
  - One-cycle pulse of wvb_rddone[chan] and hdr_rdreq[chan] together.
  - busy deasserts; return to IDLE. A new grant is possible on the next cycle.
- chan_en changes: deasserting chan_en during an event does not abort it; it only affects the next arbitration.
- Simultaneous requests: strict round robin. Back-to-back events from the same channel are allowed only when no other enabled channel is requesting.
- Only the granted channel's rdreq/rddone bits are ever asserted; all other bits are 0.
- hdr_empty rising on the granted channel mid-event is ignored (header already latched).

Optional Feature:
- Macro: WVB_ARB_EVT_CNT_EN.
- Defined:
  - evt_cnt increments by 1 in DONE, wraps at 2^32.
  - Cleared by rst.
  - Clears synchronously when chan_en == 0 while in IDLE.
- Not defined: evt_cnt is tied to 0 and no counter logic is instantiated.

Test Plan:
- Single event: ch1 header start=0x010, stop=0x013, dout_ready=1 → 4 words from ch1 data, sop on word 0, eop on word 3, dout_chan=1; then 1-cycle wvb_rddone[1] and hdr_rdreq[1]; busy low after DONE.
- Address wrap: start=0xFFE, stop=0x001 → N=4. start=stop=0x005 → N=1 with sop=eop on the same word.
- Fairness: all 4 channels non-empty continuously → grant order 0,1,2,3,0,… and no channel served twice in a row.
- Backpressure: dout_ready toggling 1010… over a 16-sample event → all 16 samples in order, none dropped or duplicated, at most 2 outstanding/buffered, outputs stable while stalled.
- Async reset asserted mid-STREAM → all outputs 0 immediately. After release, the pending channel is re-granted and its full event is streamed from the first sample.
- WVB_ARB_EVT_CNT_EN defined: 5 events → evt_cnt=5; chan_en=0 in IDLE → evt_cnt=0. Without the macro, evt_cnt stays 0 throughout.
